// File: rtl/pool2x2.sv
// pool2x2: streaming 2x2 stride-2 pooling of a raster-order N x N signed feature map.
// Optional macro POOL_AVG_EN adds a pool_mode input (0 = max, 1 = average).
module pool2x2 #(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               image_size,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
`ifdef POOL_AVG_EN
  input  logic                     pool_mode,
`endif
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     done,
  output logic                     cfg_err
);

`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int HALF_N = MAX_N / 2;
  localparam int BUF_AW = (HALF_N > 1) ? $clog2(HALF_N) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [3:0]              row_q, row_d;
  logic [3:0]              col_q, col_d;
  logic signed [ACC_W-1:0] temp_q, temp_d;
  logic signed [ACC_W-1:0] half_row_q [HALF_N];
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;
`ifdef POOL_AVG_EN
  logic                    mode_q, mode_d;
`endif

  logic                    buf_we;
  logic [BUF_AW-1:0]       buf_idx;
  logic                    size_ok;
  logic                    last_col;
  logic                    last_pix;
  logic                    in_window;
  logic [3:0]              pool_lim;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] max_res;
  logic signed [ACC_W-1:0] combined;
  logic signed [ACC_W-1:0] emit_val;

  assign size_ok   = (image_size >= 4'd2) && (32'(image_size) <= MAX_N);
  assign last_col  = (col_q == n_q - 4'd1);
  assign last_pix  = last_col && (row_q == n_q - 4'd1);
  // Odd N drops its last row and column; the pooled area is the largest even square.
  assign pool_lim  = {n_q[3:1], 1'b0};
  assign in_window = (row_q < pool_lim) && (col_q < pool_lim);
  assign buf_idx   = col_q[BUF_AW:1];

  assign in_ext  = ACC_W'(in_data);
  assign operand = (row_q[0] && !col_q[0]) ? half_row_q[buf_idx] : temp_q;
  assign max_res = (operand > in_ext) ? operand : in_ext;

`ifdef POOL_AVG_EN
  logic signed [ACC_W-1:0] sum;
  assign sum      = operand + in_ext;
  assign combined = mode_q ? sum : max_res;
  assign emit_val = mode_q ? (sum >>> 2) : max_res;
`else
  assign combined = max_res;
  assign emit_val = max_res;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    temp_d      = temp_q;
`ifdef POOL_AVG_EN
    mode_d      = mode_q;
`endif
    buf_we      = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            n_d     = image_size;
            row_d   = '0;
            col_d   = '0;
`ifdef POOL_AVG_EN
            mode_d  = pool_mode;
`endif
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          if (in_window) begin
            unique case ({row_q[0], col_q[0]})
              2'b00: temp_d = in_ext;
              2'b01: buf_we = 1'b1;
              2'b10: temp_d = combined;
              2'b11: begin
                out_valid_d = 1'b1;
                out_data_d  = emit_val[DATA_W-1:0];
              end
              default: ;
            endcase
          end
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
          if (last_pix) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      temp_q      <= '0;
`ifdef POOL_AVG_EN
      mode_q      <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      temp_q      <= temp_d;
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // NOTE: the half-row buffer is only MAX_N/2 registers, so it is reset to a known zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HALF_N; i++) half_row_q[i] <= '0;
    end else if (buf_we) begin
      half_row_q[buf_idx] <= combined;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pool2x2.sv
// Self-checking bench for pool2x2: directed and random frames against a window-level reference model.
module tb_pool2x2;
  localparam int DATA_W = 16;
  localparam int MAX_N  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [3:0]               image_size;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     done;
  logic                     cfg_err;
`ifdef POOL_AVG_EN
  logic                     pool_mode;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int pix [MAX_N][MAX_N];
  bit avg_mode = 1'b0;

  always #5 clk = ~clk;

  pool2x2 #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .image_size (image_size),
    .in_valid   (in_valid),
    .in_data    (in_data),
`ifdef POOL_AVG_EN
    .pool_mode  (pool_mode),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit later, away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: the pooled value of the 2x2 window whose bottom-right pixel is (r, c).
  function automatic int window_result(input int r, input int c, input bit avg);
    int w [4];
    int res;
    w[0] = pix[r-1][c-1];
    w[1] = pix[r-1][c];
    w[2] = pix[r][c-1];
    w[3] = pix[r][c];
    if (avg) return (w[0] + w[1] + w[2] + w[3]) >>> 2;
    res = w[0];
    for (int i = 1; i < 4; i++) if (w[i] > res) res = w[i];
    return res;
  endfunction

  function automatic int rand_sample();
    logic signed [DATA_W-1:0] v;
    v = DATA_W'($urandom);
    return int'(v);
  endfunction

  task automatic fill_random(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) pix[r][c] = rand_sample();
  endtask

  task automatic fill_ramp(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) pix[r][c] = r * n + c;
  endtask

  // Streams pix[0..n-1][0..n-1] with random gaps and checks every cycle against the model.
  task automatic run_frame(input int n, input int gap_max, input bit junk_with_start, input bit mid_start);
    int  lim;
    int  gaps;
    bit  emit;
    int  exp_val;
    lim = n - (n % 2);
    start      = 1'b1;
    image_size = 4'(n);
    in_valid   = junk_with_start;
    in_data    = 16'sh1234;
`ifdef POOL_AVG_EN
    pool_mode  = avg_mode;
`endif
    cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    check("start cfg_err", 32'(cfg_err), 0);
    check("start out_valid", 32'(out_valid), 0);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        gaps = $urandom_range(gap_max, 0);
        for (int g = 0; g < gaps; g++) begin
          if (mid_start) begin
            start      = 1'b1;
            image_size = (g % 2 == 1) ? 4'd9 : 4'd2;
          end
          cycle();
          start = 1'b0;
          check("gap out_valid", 32'(out_valid), 0);
          check("gap out_data", 32'(out_data), 0);
          check("gap cfg_err", 32'(cfg_err), 0);
        end
        in_valid = 1'b1;
        in_data  = DATA_W'(pix[r][c]);
        cycle();
        in_valid = 1'b0;
        emit    = (r % 2 == 1) && (c % 2 == 1) && (r < lim) && (c < lim);
        exp_val = emit ? window_result(r, c, avg_mode) : 0;
        check("beat out_valid", 32'(out_valid), emit ? 1 : 0);
        check("beat out_data", 32'(out_data), exp_val);
        check("beat done", 32'(done), (r == n - 1 && c == n - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    image_size = 4'd0;
    in_valid   = 1'b0;
    in_data    = '0;
`ifdef POOL_AVG_EN
    pool_mode  = 1'b0;
`endif
    repeat (3) cycle();
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset done", 32'(done), 0);
    check("reset cfg_err", 32'(cfg_err), 0);
    rst_n = 1'b1;
    cycle();

    // N=4 ramp, back to back: outputs 5, 7, 13, 15.
    fill_ramp(4);
    run_frame(4, 0, 1'b0, 1'b0);
    // N=5 ramp: outputs 6, 8, 16, 18; row/column 4 never trigger.
    fill_ramp(5);
    run_frame(5, 0, 1'b0, 1'b0);
    // N=2 signed compare: -5.
    pix[0][0] = -300;   pix[0][1] = -5;
    pix[1][0] = -32768; pix[1][1] = -7;
    run_frame(2, 0, 1'b0, 1'b0);

    // Same random N=4 frame without and with gaps.
    fill_random(4);
    run_frame(4, 0, 1'b0, 1'b0);
    run_frame(4, 3, 1'b0, 1'b0);

    // Random frames over every legal size, with a discarded beat on start and starts during RUN.
    for (int k = 0; k < 14; k++) begin
      fill_random(2 + (k % 7));
      run_frame(2 + (k % 7), (k < 7) ? 0 : 3, k[0], k[1]);
    end

    // Illegal sizes pulse cfg_err for one cycle; idle beats produce nothing.
    for (int k = 0; k < 3; k++) begin
      start      = 1'b1;
      image_size = (k == 0) ? 4'd9 : ((k == 1) ? 4'd0 : 4'd1);
      cycle();
      start = 1'b0;
      check("illegal cfg_err", 32'(cfg_err), 1);
      cycle();
      check("cfg_err pulse end", 32'(cfg_err), 0);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i * 1000);
      cycle();
      check("idle out_valid", 32'(out_valid), 0);
      check("idle done", 32'(done), 0);
    end
    in_valid = 1'b0;

    // Reset mid-frame after 6 beats of an N=4 frame clears the pending output.
    start      = 1'b1;
    image_size = 4'd4;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(100 + i);
      cycle();
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 1);
    check("pre-reset out_data", 32'(out_data), 105);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset out_data", 32'(out_data), 0);
    check("async reset done", 32'(done), 0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      cycle();
      check("post-reset no start", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    fill_random(2);
    run_frame(2, 1, 1'b0, 1'b0);

`ifdef POOL_AVG_EN
    avg_mode  = 1'b1;
    pix[0][0] = -1; pix[0][1] = -2;
    pix[1][0] = -3; pix[1][1] = -4;
    run_frame(2, 0, 1'b0, 1'b0);
    pix[0][0] = 32767; pix[0][1] = 32767;
    pix[1][0] = 32767; pix[1][1] = 32767;
    run_frame(2, 0, 1'b0, 1'b0);
    pix[0][0] = -32768; pix[0][1] = -32768;
    pix[1][0] = -32768; pix[1][1] = -32767;
    run_frame(2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      fill_random(4 + k);
      run_frame(4 + k, 2, 1'b0, 1'b0);
    end
    avg_mode = 1'b0;
    fill_random(4);
    run_frame(4, 0, 1'b0, 1'b0);
`endif

    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pool2x2.md
# pool2x2

- Streaming 2x2 stride-2 pooling stage placed directly downstream of the 2D convolution block.
- Consumes the convolution's raster-order stream of signed 16-bit results for one N x N feature map and emits the floor(N/2) x floor(N/2) pooled map in raster order.
- Holds one half-row of partial results, so it never buffers a whole frame.

## Interface
Parameters:
- DATA_W, 16, width of input and output samples (signed, two's complement).
- MAX_N, 8, largest supported feature-map side; sizes the half-row buffer at MAX_N/2 entries.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; image_size is sampled on this cycle.
- image_size  in  4  feature-map side N; the legal range is 2..MAX_N.
- in_valid  in  1  qualifies in_data; driven by the convolution block's out_valid.
- in_data  in  DATA_W  convolution result sample, signed.
- out_valid  out  1  qualifies out_data.
- out_data  out  DATA_W  pooled sample, signed.
- done  out  1  one-cycle pulse marking the end of the frame.
- cfg_err  out  1  one-cycle pulse flagging an illegal image_size at start.

## Operation
- States: IDLE and RUN.
- IDLE, start with legal N: capture N, clear the row/column counters, go to RUN.
- IDLE, start with illegal N (0, 1, or greater than MAX_N): pulse cfg_err the next cycle and stay in IDLE.
- IDLE, in_valid: ignored.
- RUN: each in_valid beat is pixel (r, c); c advances and wraps to 0 at N-1, after which r increments. Cycles without in_valid are gaps; they change no state.
- RUN to IDLE: after the N*N-th beat is accepted.
- start during RUN is ignored; no cfg_err is raised.
- Even r, even c: hold in_data in temp.
- Even r, odd c: buf[c/2] = max(temp, in_data).
- Odd r, even c: temp = max(buf[c/2], in_data).
- Odd r, odd c: emit max(temp, in_data).
- Odd N: pixels with c = N-1 or r = N-1 are consumed and counted but never contribute to, or trigger, an output.
- Comparisons are signed. Output order is raster order over pooled rows and columns.
- start and in_valid in the same IDLE cycle: start is taken and that in_valid beat is discarded.

## Timing
- Reset values: out_valid = 0, out_data = 0, done = 0, cfg_err = 0, state = IDLE, counters = 0, buf and temp = 0.
- out_data is 0 in every cycle where out_valid = 0.
- Latency: out_valid/out_data are registered and appear 1 cycle after the in_valid beat of pixel (odd r, odd c).
- Throughput: one input per cycle with no backpressure. The block must accept back-to-back beats indefinitely.
- done is asserted 1 cycle after the N*N-th beat. For even N it coincides with the final out_valid.
- A new start is accepted in the same cycle done is high, since the state is already IDLE.
- Reset asserted mid-frame clears everything immediately, including any pending output. The next frame requires a fresh start.

## Configuration
- POOL_AVG_EN defined:
  - Adds input port pool_mode (1 bit), sampled at start: 0 = max, 1 = average.
  - Average mode accumulates an 18-bit signed sum of the 4 window samples in temp and buf.
  - Emits sum >>> 2, an arithmetic shift (floor toward -inf). The result always fits DATA_W.
- POOL_AVG_EN undefined: pool_mode port is absent, the block is max-only, and temp/buf are DATA_W wide.

## Test plan
- N=4, inputs 0..15 back-to-back -> out_valid at the beats after pixels 5, 7, 13, 15 with values 5, 7, 13, 15; done with the last output.
- N=5, inputs 0..24 -> 4 outputs (6, 8, 16, 18); no output is triggered by column 4 or row 4; done 1 cycle after beat 25.
- N=2, inputs -300, -5, -32768, -7 -> single output -5 (signed compare).
- N=4 with random 0-3 cycle gaps between beats -> outputs identical to the gap-free run; no out_valid during gaps.
- start with image_size=9 -> cfg_err pulse, then in_valid beats produce nothing. rst_n low after 6 beats of an N=4 frame -> all outputs 0; a new N=2 frame then works.
- POOL_AVG_EN, pool_mode=1, N=2, inputs -1, -2, -3, -4 -> out_data = -3 (sum -10 >>> 2); inputs 32767 x4 -> 32767.
